// File: rtl/pcie_link_ctrl_pkg.sv
// Shared symbol values, lane count and link state encoding for the 4-lane link controller.
package pcie_link_ctrl_pkg;

  localparam int         LANES    = 4;
  localparam logic [7:0] COM      = 8'hBC;
  localparam logic [7:0] IDLE     = 8'h7C;
  localparam logic [31:0] COM_WORD = {4{COM}};

  typedef enum logic [1:0] {
    TRAIN      = 2'd0,
    WAIT_ALIGN = 2'd1,
    ACTIVE     = 2'd2
  } link_state_e;

endpackage

// File: rtl/pcie_link_ctrl_lane_pack.sv
// Four-byte lane packing buffer: bytes fill lanes 0..3, unfilled lanes read as IDLE control symbols.
module pcie_link_ctrl_lane_pack
  import pcie_link_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        flush,
  input  logic        emit,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [3:0]  kchar,
  output logic        full,
  output logic [2:0]  fill
);

  logic [7:0] lane_buf_r [LANES];
  logic [2:0] fill_r;

  // Append at the fill pointer; flush or emit empties the buffer and drops any same-cycle push.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_r <= 3'd0;
      for (int i = 0; i < LANES; i++) lane_buf_r[i] <= 8'h00;
    end else if (flush || emit) begin
      fill_r <= 3'd0;
    end else if (push && !full) begin
      lane_buf_r[fill_r[1:0]] <= data;
      fill_r                  <= fill_r + 3'd1;
    end else begin
      fill_r <= fill_r;
    end
  end

  assign full = (fill_r == 3'(LANES));
  assign fill = fill_r;

  // Present the word as it would go out now: data in filled lanes, IDLE elsewhere.
  always_comb begin
    word  = 32'h0000_0000;
    kchar = 4'h0;
    for (int i = 0; i < LANES; i++) begin
      if (3'(i) < fill_r) begin
        word[8*i +: 8] = lane_buf_r[i];
        kchar[i]       = 1'b0;
      end else begin
        word[8*i +: 8] = IDLE;
        kchar[i]       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_link_ctrl.sv
// Link bring-up FSM and word-period striping scheduler driving four TX lane serializers.
module pcie_link_ctrl
  import pcie_link_ctrl_pkg::*;
#(
  parameter int TRAIN_WORDS   = 4,
  parameter int TIMEOUT_WORDS = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  DATA,
  input  logic        VALID,
  input  logic [3:0]  rx_aligned,
  output logic        host_ready,
  output logic [31:0] lane_word,
  output logic [3:0]  lane_kchar,
  output logic        lane_load,
  output logic        link_up,
  output logic [3:0]  retry_cnt
);

  localparam int MAX_WORDS = (TRAIN_WORDS > TIMEOUT_WORDS) ? TRAIN_WORDS : TIMEOUT_WORDS;
  localparam int CNT_W     = $clog2(MAX_WORDS) + 1;

  link_state_e      state_r, state_next_s;
  logic [2:0]       bit_cnt_r;
  logic [CNT_W-1:0] word_cnt_r, word_cnt_next_s;
  logic [3:0]       retry_cnt_r, retry_cnt_next_s;
  logic             host_ready_r, lane_load_r, link_up_r;
  logic [31:0]      lane_word_r;
  logic [3:0]       lane_kchar_r;

  logic        boundary_s, all_aligned_s, link_loss_s, push_s, emit_s, ready_next_s;
  logic [2:0]  fill_s, fill_next_s;
  logic [31:0] pack_word_s;
  logic [3:0]  pack_kchar_s;
  logic        pack_full_s;

  assign boundary_s    = (bit_cnt_r == 3'd7);
  assign all_aligned_s = (rx_aligned == 4'hF);
  assign link_loss_s   = (state_r == ACTIVE) && !all_aligned_s;
  assign push_s        = VALID && host_ready_r;
  assign emit_s        = boundary_s && (state_r == ACTIVE);

  pcie_link_ctrl_lane_pack u_lane_pack (
    .clk   (CLK),
    .reset (RESET),
    .push  (push_s),
    .flush (link_loss_s),
    .emit  (emit_s),
    .data  (DATA),
    .word  (pack_word_s),
    .kchar (pack_kchar_s),
    .full  (pack_full_s),
    .fill  (fill_s)
  );

  // Next-state, word/timeout counter and retry counter.
  always_comb begin
    state_next_s     = state_r;
    word_cnt_next_s  = word_cnt_r;
    retry_cnt_next_s = retry_cnt_r;
    case (state_r)
      TRAIN: begin
        if (boundary_s) begin
          if (word_cnt_r == CNT_W'(TRAIN_WORDS - 1)) begin
            state_next_s    = WAIT_ALIGN;
            word_cnt_next_s = '0;
          end else begin
            word_cnt_next_s = word_cnt_r + 1'b1;
          end
        end else begin
          word_cnt_next_s = word_cnt_r;
        end
      end
      WAIT_ALIGN: begin
        if (boundary_s) begin
          if (all_aligned_s) begin
            state_next_s    = ACTIVE;
            word_cnt_next_s = '0;
          end else if (word_cnt_r == CNT_W'(TIMEOUT_WORDS - 1)) begin
            state_next_s    = TRAIN;
            word_cnt_next_s = '0;
            if (retry_cnt_r != 4'hF) begin
              retry_cnt_next_s = retry_cnt_r + 4'd1;
            end else begin
              retry_cnt_next_s = retry_cnt_r;
            end
          end else begin
            word_cnt_next_s = word_cnt_r + 1'b1;
          end
        end else begin
          word_cnt_next_s = word_cnt_r;
        end
      end
      ACTIVE: begin
        if (!all_aligned_s) begin
          state_next_s    = TRAIN;
          word_cnt_next_s = '0;
        end else begin
          state_next_s = ACTIVE;
        end
      end
      default: begin
        state_next_s    = TRAIN;
        word_cnt_next_s = '0;
      end
    endcase
  end

  // Ready looks one cycle ahead so the boundary cycle never sees host_ready high.
  always_comb begin
    fill_next_s = fill_s;
    if (link_loss_s || emit_s) begin
      fill_next_s = 3'd0;
    end else if (push_s && !pack_full_s) begin
      fill_next_s = fill_s + 3'd1;
    end else begin
      fill_next_s = fill_s;
    end
    ready_next_s = (state_next_s == ACTIVE) && (fill_next_s < 3'd4) && (bit_cnt_r != 3'd6);
  end

  // State, counters and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= TRAIN;
      bit_cnt_r    <= 3'd0;
      word_cnt_r   <= '0;
      retry_cnt_r  <= 4'd0;
      host_ready_r <= 1'b0;
      lane_load_r  <= 1'b0;
      link_up_r    <= 1'b0;
      lane_word_r  <= COM_WORD;
      lane_kchar_r <= 4'hF;
    end else begin
      state_r      <= state_next_s;
      bit_cnt_r    <= bit_cnt_r + 3'd1;
      word_cnt_r   <= word_cnt_next_s;
      retry_cnt_r  <= retry_cnt_next_s;
      host_ready_r <= ready_next_s;
      lane_load_r  <= boundary_s;
      link_up_r    <= (state_next_s == ACTIVE);
      if (boundary_s) begin
        if ((state_r == ACTIVE) && all_aligned_s) begin
          lane_word_r  <= pack_word_s;
          lane_kchar_r <= pack_kchar_s;
        end else begin
          lane_word_r  <= COM_WORD;
          lane_kchar_r <= 4'hF;
        end
      end else begin
        lane_word_r  <= lane_word_r;
        lane_kchar_r <= lane_kchar_r;
      end
    end
  end

  assign host_ready = host_ready_r;
  assign lane_load  = lane_load_r;
  assign link_up    = link_up_r;
  assign retry_cnt  = retry_cnt_r;
  assign lane_word  = lane_word_r;
  assign lane_kchar = lane_kchar_r;

endmodule

// File: tb/tb_pcie_link_ctrl.sv
// Self-checking bench for pcie_link_ctrl against a cycle-counting behavioural model with a byte queue.
module tb_pcie_link_ctrl;

  localparam int TRAIN_W = 4;
  localparam int TMO_W   = 16;
  localparam int M_TRAIN = 0;
  localparam int M_WAIT  = 1;
  localparam int M_ACT   = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  DATA = 8'h00;
  logic        VALID = 1'b0;
  logic [3:0]  rx_aligned = 4'hF;
  logic        host_ready, lane_load, link_up;
  logic [31:0] lane_word;
  logic [3:0]  lane_kchar, retry_cnt;

  int checks = 0;
  int errors = 0;

  pcie_link_ctrl #(.TRAIN_WORDS(TRAIN_W), .TIMEOUT_WORDS(TMO_W)) dut (
    .CLK(CLK), .RESET(RESET), .DATA(DATA), .VALID(VALID), .rx_aligned(rx_aligned),
    .host_ready(host_ready), .lane_word(lane_word), .lane_kchar(lane_kchar),
    .lane_load(lane_load), .link_up(link_up), .retry_cnt(retry_cnt)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: cycle index, mode, words spent in mode, queue of buffered bytes.
  int          m_k, m_mode, m_words;
  logic [7:0]  m_q[$];
  logic        m_ready, m_load, m_link;
  logic [3:0]  m_retry, m_kchar;
  logic [31:0] m_word;

  logic [42:0] dut_vec, exp_vec;
  assign dut_vec = {host_ready, lane_load, link_up, retry_cnt, lane_kchar, lane_word};
  assign exp_vec = {m_ready, m_load, m_link, m_retry, m_kchar, m_word};

  task automatic model_init();
    m_k = 0; m_mode = M_TRAIN; m_words = 0; m_q.delete();
    m_ready = 1'b0; m_load = 1'b0; m_link = 1'b0; m_retry = 4'd0;
    m_kchar = 4'hF; m_word = 32'hBCBCBCBC;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic [3:0] rx);
    int  ph;
    bit  bnd, acc, loss;
    ph   = m_k % 8;
    bnd  = (ph == 7);
    acc  = v && m_ready;
    loss = (m_mode == M_ACT) && (rx != 4'hF);
    m_load = bnd;
    if (bnd) begin
      if (m_mode == M_ACT && !loss) begin
        for (int i = 0; i < 4; i++) begin
          if (i < m_q.size()) begin m_word[8*i +: 8] = m_q[i]; m_kchar[i] = 1'b0; end
          else begin m_word[8*i +: 8] = 8'h7C; m_kchar[i] = 1'b1; end
        end
      end else begin
        m_word = 32'hBCBCBCBC; m_kchar = 4'hF;
      end
    end
    if (loss || (bnd && m_mode == M_ACT)) m_q.delete();
    else if (acc) m_q.push_back(d);
    if (m_mode == M_TRAIN) begin
      if (bnd) begin
        m_words++;
        if (m_words == TRAIN_W) begin m_mode = M_WAIT; m_words = 0; end
      end
    end else if (m_mode == M_WAIT) begin
      if (bnd) begin
        m_words++;
        if (rx == 4'hF) begin m_mode = M_ACT; m_words = 0; end
        else if (m_words == TMO_W) begin
          m_mode = M_TRAIN; m_words = 0;
          if (m_retry != 4'd15) m_retry = m_retry + 4'd1;
        end
      end
    end else if (loss) begin
      m_mode = M_TRAIN; m_words = 0;
    end
    m_link  = (m_mode == M_ACT);
    m_ready = (m_mode == M_ACT) && (m_q.size() < 4) && (ph != 6);
    m_k++;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic [3:0] rx);
    VALID = v; DATA = d; rx_aligned = rx;
    model_step(v, d, rx);
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RESET = 1'b1; VALID = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_init();
  endtask

  task automatic wait_phase(input int p);
    for (int g = 0; g < 8 && (m_k % 8) != p; g++) step(1'b0, 8'h00, 4'hF);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_vec !== {1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 32'hBCBCBCBC}) begin
      errors++; $display("FAIL reset_values got %h expected %h", dut_vec,
                         {1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 32'hBCBCBCBC});
    end
  endtask

  task automatic test_bringup();
    int first_up = -1;
    int loads = 0;
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 8'h00, 4'hF);
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL bringup k=%0d got %h expected %h", m_k, dut_vec, exp_vec); end
      if (link_up === 1'b1 && first_up < 0) first_up = m_k;
      if (lane_load === 1'b1) begin
        loads++;
        checks++;
        if (lane_word !== 32'hBCBCBCBC || lane_kchar !== 4'hF) begin
          errors++; $display("FAIL bringup_com k=%0d got %h/%h expected bcbcbcbc/f", m_k, lane_word, lane_kchar);
        end
      end
    end
    checks++;
    if (first_up != 40) begin errors++; $display("FAIL link_up_cycle got %0d expected 40", first_up); end
    checks++;
    if (loads != 5) begin errors++; $display("FAIL bringup_loads got %0d expected 5", loads); end
  endtask

  task automatic test_stream();
    logic [7:0] sb[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int  idx = 0;
    bit  seen = 1'b0;
    bit  v, acc;
    wait_phase(0);
    for (int c = 0; c < 20 && !seen; c++) begin
      v   = (idx < 4);
      acc = v && m_ready;
      step(v, v ? sb[idx] : 8'h00, 4'hF);
      if (acc) idx++;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL stream k=%0d got %h expected %h", m_k, dut_vec, exp_vec); end
      if (idx == 4 && (m_k % 8) != 0) begin
        checks++;
        if (host_ready !== 1'b0) begin errors++; $display("FAIL stream_full_ready k=%0d got %b expected 0", m_k, host_ready); end
      end
      if (lane_load === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (lane_word !== 32'h44332211 || lane_kchar !== 4'h0) begin
          errors++; $display("FAIL stream_word got %h/%h expected 44332211/0", lane_word, lane_kchar);
        end
        checks++;
        if (host_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_back got %b expected 1", host_ready); end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stream_timeout got no load expected one"); end
  endtask

  task automatic test_single();
    int seen = 0;
    wait_phase(0);
    step(1'b1, 8'hA5, 4'hF);
    for (int c = 0; c < 20 && seen < 2; c++) begin
      step(1'b0, 8'h00, 4'hF);
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL single k=%0d got %h expected %h", m_k, dut_vec, exp_vec); end
      if (lane_load === 1'b1) begin
        seen++;
        checks++;
        if (seen == 1 && (lane_word !== 32'h7C7C7CA5 || lane_kchar !== 4'hE)) begin
          errors++; $display("FAIL single_word got %h/%h expected 7c7c7ca5/e", lane_word, lane_kchar);
        end else if (seen == 2 && (lane_word !== 32'h7C7C7C7C || lane_kchar !== 4'hF)) begin
          errors++; $display("FAIL idle_word got %h/%h expected 7c7c7c7c/f", lane_word, lane_kchar);
        end
      end
    end
    checks++;
    if (seen != 2) begin errors++; $display("FAIL single_timeout got %0d loads expected 2", seen); end
  endtask

  task automatic test_link_loss();
    bit seen = 1'b0;
    wait_phase(0);
    step(1'b1, 8'hC1, 4'hF);
    step(1'b1, 8'hC2, 4'hF);
    step(1'b0, 8'h00, 4'hF);
    step(1'b0, 8'h00, 4'hF);
    step(1'b0, 8'h00, 4'hB);
    checks++;
    if (link_up !== 1'b0 || host_ready !== 1'b0) begin
      errors++; $display("FAIL loss_link_up got %b/%b expected 0/0", link_up, host_ready);
    end
    for (int c = 0; c < 10 && !seen; c++) begin
      step(1'b0, 8'h00, 4'hF);
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL loss k=%0d got %h expected %h", m_k, dut_vec, exp_vec); end
      if (lane_load === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (lane_word !== 32'hBCBCBCBC || lane_kchar !== 4'hF) begin
          errors++; $display("FAIL loss_word got %h/%h expected bcbcbcbc/f", lane_word, lane_kchar);
        end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL loss_timeout got no load expected one"); end
  endtask

  task automatic test_reset_midword();
    int first = -1;
    for (int c = 0; c < 200 && m_mode != M_ACT; c++) step(1'b0, 8'h00, 4'hF);
    wait_phase(0);
    step(1'b1, 8'h5A, 4'hF);
    wait_phase(3);
    checks++;
    if (link_up !== 1'b1) begin errors++; $display("FAIL midreset_pre got link_up %b expected 1", link_up); end
    apply_reset();
    checks++;
    if (dut_vec !== {1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 32'hBCBCBCBC}) begin
      errors++; $display("FAIL midreset_values got %h expected %h", dut_vec,
                         {1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 32'hBCBCBCBC});
    end
    for (int c = 0; c < 16 && first < 0; c++) begin
      step(1'b0, 8'h00, 4'hF);
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL midreset k=%0d got %h expected %h", m_k, dut_vec, exp_vec); end
      if (lane_load === 1'b1) first = m_k;
    end
    checks++;
    if (first != 8) begin errors++; $display("FAIL midreset_first_load got %0d expected 8", first); end
  endtask

  task automatic test_random();
    logic [3:0] rx;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      if (m_mode == M_ACT) rx = ($urandom_range(0, 99) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      else rx = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      step($urandom_range(0, 2) != 0, 8'($urandom), rx);
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL random k=%0d got %h expected %h", m_k, dut_vec, exp_vec); end
    end
  endtask

  task automatic test_retry();
    int first = -1;
    apply_reset();
    for (int c = 0; c < 2600; c++) begin
      step(1'b0, 8'h00, 4'h7);
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL retry k=%0d got %h expected %h", m_k, dut_vec, exp_vec); end
      if (retry_cnt === 4'd1 && first < 0) first = m_k;
    end
    checks++;
    if (first != 160) begin errors++; $display("FAIL retry_first got %0d expected 160", first); end
    checks++;
    if (retry_cnt !== 4'd15 || link_up !== 1'b0) begin
      errors++; $display("FAIL retry_sat got %0d/%b expected 15/0", retry_cnt, link_up);
    end
  endtask

  initial begin
    model_init();
    test_reset();
    test_bringup();
    test_stream();
    test_single();
    test_link_loss();
    test_reset_midword();
    test_random();
    test_retry();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
